// File: rtl/pong_sync_counters.sv
// -----------------------------------------------------------------------------
// pong_sync_counters
//
// Purpose:
//   Free-running horizontal and vertical video counters for the Pong timing
//   chain. The pixel-clock enable advances the horizontal counter. Each line
//   has H_TOTAL states. The vertical counter advances once per line, and each
//   frame has V_TOTAL lines. The line strobe (hreset) and frame strobe (vreset)
//   are registered. Each strobe is high for the whole last state of its
//   counter. frame_odd toggles on every frame wrap.
//
// Parameters:
//   H_TOTAL   horizontal states per line (2..512, default 455)
//   V_TOTAL   lines per frame            (2..512, default 262)
//
// Ports:
//   mclk       in   master clock, rising edge
//   _reset     in   asynchronous active-low reset
//   clk_en     in   pixel-clock enable; state advances only when high
//   h[8:0]     out  horizontal count (bit n = h(2^n))
//   v[8:0]     out  vertical count   (bit n = v(2^n))
//   hreset     out  high while h == H_TOTAL-1
//   vreset     out  high while v == V_TOTAL-1
//   frame_odd  out  toggles at every frame wrap
// -----------------------------------------------------------------------------
module pong_sync_counters #(
  parameter int H_TOTAL = 455,
  parameter int V_TOTAL = 262
) (
  input  logic       mclk,
  input  logic       _reset,
  input  logic       clk_en,
  output logic [8:0] h,
  output logic [8:0] v,
  output logic       hreset,
  output logic       vreset,
  output logic       frame_odd
);

  localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);

  logic [8:0] h_q, h_d;
  logic [8:0] v_q, v_d;
  logic       hreset_q, hreset_d;
  logic       vreset_q, vreset_d;
  logic       frame_odd_q, frame_odd_d;
  logic       h_wrap;

  // A '>=' test is used instead of '=='. This lets a corrupted out-of-range
  // count fall back to 0 on the next advance instead of running on to 511.
  always_comb begin
    h_wrap      = (h_q >= H_LAST);
    h_d         = h_wrap ? 9'd0 : h_q + 9'd1;
    v_d         = v_q;
    frame_odd_d = frame_odd_q;
    if (h_wrap) begin
      if (v_q >= V_LAST) begin
        v_d         = 9'd0;
        frame_odd_d = ~frame_odd_q;
      end else begin
        v_d = v_q + 9'd1;
      end
    end
    // The strobes decode the next count, so they line up with the count
    // register and add no latency.
    hreset_d = (h_d == H_LAST);
    vreset_d = (v_d == V_LAST);
  end

  always_ff @(posedge mclk or negedge _reset) begin
    if (!_reset) begin
      h_q         <= 9'd0;
      v_q         <= 9'd0;
      hreset_q    <= 1'b0;
      vreset_q    <= 1'b0;
      frame_odd_q <= 1'b0;
    end else if (clk_en) begin
      h_q         <= h_d;
      v_q         <= v_d;
      hreset_q    <= hreset_d;
      vreset_q    <= vreset_d;
      frame_odd_q <= frame_odd_d;
    end
  end

  assign h         = h_q;
  assign v         = v_q;
  assign hreset    = hreset_q;
  assign vreset    = vreset_q;
  assign frame_odd = frame_odd_q;

endmodule

// File: tb/tb_pong_sync_counters.sv
// -----------------------------------------------------------------------------
// tb_pong_sync_counters
//
// Purpose:
//   Directed test of pong_sync_counters using three instances on one clock.
//     a: default sizes (455 x 262). Covers reset, line wrap and enable gating.
//     b: 455 x 8. Covers frame wrap, vreset width and mid-frame async reset,
//        with a short enough frame to keep the run small.
//     c: 4 x 3. Covers the parameter override under randomly spaced enables.
//   Inputs change on the falling edge of mclk. Outputs are sampled on the
//   falling edge, or between edges for the async reset check.
// -----------------------------------------------------------------------------
module tb_pong_sync_counters;

  logic mclk = 1'b0;
  always #5 mclk = ~mclk;

  logic       rst_a = 1'b0, en_a = 1'b0;
  logic       rst_b = 1'b0, en_b = 1'b0;
  logic       rst_c = 1'b0, en_c = 1'b0;
  logic [8:0] h_a, v_a, h_b, v_b, h_c, v_c;
  logic       hr_a, vr_a, fo_a, hr_b, vr_b, fo_b, hr_c, vr_c, fo_c;

  pong_sync_counters u_a (
    .mclk(mclk), ._reset(rst_a), .clk_en(en_a),
    .h(h_a), .v(v_a), .hreset(hr_a), .vreset(vr_a), .frame_odd(fo_a)
  );

  pong_sync_counters #(.H_TOTAL(455), .V_TOTAL(8)) u_b (
    .mclk(mclk), ._reset(rst_b), .clk_en(en_b),
    .h(h_b), .v(v_b), .hreset(hr_b), .vreset(vr_b), .frame_odd(fo_b)
  );

  pong_sync_counters #(.H_TOTAL(4), .V_TOTAL(3)) u_c (
    .mclk(mclk), ._reset(rst_c), .clk_en(en_c),
    .h(h_c), .v(v_c), .hreset(hr_c), .vreset(vr_c), .frame_odd(fo_c)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int vcnt;
    int cnt;
    int k;
    int eh;
    int ev;

    // ---------------- reset held with random enable ----------------
    for (int i = 0; i < 10; i++) begin
      @(negedge mclk);
      en_a = 1'($urandom_range(0, 1));
    end
    check("a_rst_h", 32'(h_a), 0);
    check("a_rst_v", 32'(v_a), 0);
    check("a_rst_hreset", 32'(hr_a), 0);
    check("a_rst_vreset", 32'(vr_a), 0);
    check("a_rst_frame_odd", 32'(fo_a), 0);
    $display("reset held: h=%0d v=%0d hreset=%0d vreset=%0d frame_odd=%0d", h_a, v_a, hr_a, vr_a, fo_a);

    // ---------------- release, first advance ----------------
    @(negedge mclk);
    rst_a = 1'b1;
    en_a  = 1'b1;
    @(negedge mclk);
    check("a_first_h", 32'(h_a), 1);
    $display("first enabled edge: h=%0d", h_a);

    // ---------------- line wrap ----------------
    repeat (453) @(negedge mclk);
    check("a_line_end_h", 32'(h_a), 454);
    check("a_line_end_hreset", 32'(hr_a), 1);
    check("a_line_end_v", 32'(v_a), 0);
    $display("line end: h=%0d hreset=%0d v=%0d", h_a, hr_a, v_a);
    @(negedge mclk);
    check("a_line_wrap_h", 32'(h_a), 0);
    check("a_line_wrap_hreset", 32'(hr_a), 0);
    check("a_line_wrap_v", 32'(v_a), 1);
    $display("line wrap: h=%0d hreset=%0d v=%0d", h_a, hr_a, v_a);

    // ---------------- enable gating: 1000 edges, every other enabled ----------------
    for (int i = 0; i < 1000; i++) begin
      en_a = (i % 2 == 0);
      @(negedge mclk);
    end
    // 500 advances from (h=0, v=1): 500 = 455 + 45, so h=45 on line 2
    check("a_gate_h", 32'(h_a), 45);
    check("a_gate_v", 32'(v_a), 2);
    $display("gated 1000 edges: h=%0d v=%0d", h_a, v_a);

    en_a = 1'b1;
    repeat (409) @(negedge mclk);
    en_a = 1'b0;
    repeat (100) @(negedge mclk);
    check("a_hold_h", 32'(h_a), 454);
    check("a_hold_hreset", 32'(hr_a), 1);
    check("a_hold_v", 32'(v_a), 2);
    $display("hold 100 edges disabled: h=%0d hreset=%0d v=%0d", h_a, hr_a, v_a);

    // ---------------- frame wrap on u_b (455 x 8) ----------------
    rst_b = 1'b1;
    en_b  = 1'b1;
    vcnt  = 0;
    for (int i = 1; i <= 3640; i++) begin
      @(negedge mclk);
      if (vr_b) vcnt++;
      if (i == 3639) begin
        check("b_frame_end_h", 32'(h_b), 454);
        check("b_frame_end_v", 32'(v_b), 7);
        check("b_frame_end_hreset", 32'(hr_b), 1);
        check("b_frame_end_vreset", 32'(vr_b), 1);
        check("b_frame_end_frame_odd", 32'(fo_b), 0);
        $display("frame end: h=%0d v=%0d hreset=%0d vreset=%0d", h_b, v_b, hr_b, vr_b);
      end
      if (i == 3640) begin
        check("b_frame_wrap_h", 32'(h_b), 0);
        check("b_frame_wrap_v", 32'(v_b), 0);
        check("b_frame_wrap_hreset", 32'(hr_b), 0);
        check("b_frame_wrap_vreset", 32'(vr_b), 0);
        check("b_frame_wrap_frame_odd", 32'(fo_b), 1);
        $display("frame wrap: h=%0d v=%0d frame_odd=%0d", h_b, v_b, fo_b);
      end
    end
    check("b_vreset_width", 32'(vcnt), 455);
    $display("vreset high for %0d enabled edges", vcnt);

    // ---------------- async reset mid-frame ----------------
    repeat (5 * 455 + 200) @(negedge mclk);
    check("b_mid_h", 32'(h_b), 200);
    check("b_mid_v", 32'(v_b), 5);
    #2;
    rst_b = 1'b0;
    #1;
    check("b_async_h", 32'(h_b), 0);
    check("b_async_v", 32'(v_b), 0);
    check("b_async_hreset", 32'(hr_b), 0);
    check("b_async_vreset", 32'(vr_b), 0);
    check("b_async_frame_odd", 32'(fo_b), 0);
    $display("async reset between edges: h=%0d v=%0d frame_odd=%0d", h_b, v_b, fo_b);
    @(negedge mclk);
    rst_b = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge mclk);
      cnt++;
      if (fo_b) break;
    end
    check("b_wrap_after_release", 32'(cnt), 3640);
    $display("frame wrap after release at edge %0d", cnt);

    // ---------------- parameter override on u_c (4 x 3) ----------------
    rst_c = 1'b1;
    k = 0;
    for (int i = 0; i < 200 && k < 26; i++) begin
      en_c = 1'($urandom_range(0, 1));
      @(negedge mclk);
      if (en_c) begin
        k++;
        eh = k % 4;
        ev = (k / 4) % 3;
        check("c_h", 32'(h_c), 32'(eh));
        check("c_v", 32'(v_c), 32'(ev));
        check("c_hreset", 32'(hr_c), 32'(eh == 3));
        check("c_vreset", 32'(vr_c), 32'(ev == 2));
        check("c_frame_odd", 32'(fo_c), 32'((k / 12) % 2));
        $display("small edge %0d: h=%0d v=%0d hreset=%0d vreset=%0d frame_odd=%0d", k, h_c, v_c, hr_c, vr_c, fo_c);
      end
    end
    check("c_progress", 32'(k), 26);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pong_sync_counters.md
# pong_sync_counters

Free-running horizontal and vertical video counters for the Pong timing chain. The block divides the enabled pixel clock into 455 horizontal states per line and 262 lines per frame. It drives the counter bits `h[8:0]` / `v[8:0]` and the line/frame reset strobes `hreset` / `vreset`. The vertical sync circuit consumes `vreset`, `v[2]` (v4), `v[3]` (v8) and `v[4]` (v16); the horizontal sync/blank, net and score logic consume the same counter bits.

## Interface
Parameters:
- `H_TOTAL`, 455, horizontal states per line; legal range 2..512.
- `V_TOTAL`, 262, lines per frame; legal range 2..512.

Ports:
- `mclk`  input  1  master clock; all state changes on its rising edge.
- `_reset`  input  1  reset, asynchronous, active-low.
- `clk_en`  input  1  pixel-clock enable; counters advance only on `mclk` edges with `clk_en`=1.
- `h`  output  9  horizontal count; bit n is the original h(2^n) signal (h1..h256).
- `v`  output  9  vertical count; bit n is v(2^n) (v1..v256).
- `hreset`  output  1  high for the whole state `h == H_TOTAL-1`.
- `vreset`  output  1  high for the whole line `v == V_TOTAL-1`.
- `frame_odd`  output  1  toggles at every frame wrap.

## Operation
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `_reset` low, asynchronously: `h`=0, `v`=0, `hreset`=0, `vreset`=0, `frame_odd`=0.
- `clk_en`=0: all state holds, including the strobes.
- `clk_en`=1, horizontal counter:
  - If `h` < `H_TOTAL-1`, then `h` <= `h`+1.
  - If `h` == `H_TOTAL-1`, then `h` <= 0.
- `hreset` <= (next `h` == `H_TOTAL-1`), so it is high exactly while `h` == `H_TOTAL-1`.
- Line advance occurs on an enabled edge where `h` == `H_TOTAL-1`:
  - If `v` < `V_TOTAL-1`, then `v` <= `v`+1.
  - If `v` == `V_TOTAL-1`, then `v` <= 0 and `frame_odd` toggles.
- `vreset` <= (next `v` == `V_TOTAL-1`), so it is high exactly while `v` == `V_TOTAL-1`. That is one full line, `H_TOTAL` enabled periods.
- Simultaneous wrap: with `h`=`H_TOTAL-1`, `v`=`V_TOTAL-1` and `clk_en`=1, the same edge sets `h`=0, `v`=0, `hreset`=0, `vreset`=0 and toggles `frame_odd`.
- Out-of-range state cannot arise from reset. Any `h` ≥ `H_TOTAL` or `v` ≥ `V_TOTAL` returns to 0 on the next enabled advance (`>=` comparison, not `==`).
- Widths:
  - 9-bit counters, unsigned, with no carry beyond bit 8.
  - Unused high bits stay 0 when a parameter is below 257.

## Timing
- Line period: `H_TOTAL` enabled cycles.
- Frame period: `H_TOTAL`×`V_TOTAL` enabled cycles; 119 210 at defaults.
- `hreset` rises on the same edge that `h` becomes `H_TOTAL-1` and falls on the edge `h` becomes 0. There is zero added latency relative to `h`.
- `v` and `vreset` change only on the edge where `h` goes `H_TOTAL-1`→0, so they are stable for the whole line. Downstream sync latches may sample `v` bits on any enabled edge.
- `_reset` deassertion is not synchronized inside the block. The first advance is on the first enabled `mclk` edge after release (`h` 0→1).
- `_reset` asserted mid-frame: outputs clear immediately, with no `mclk` edge needed. Counting restarts from 0/0 with `frame_odd`=0.
- `clk_en` may be held at 1 (count at `mclk` rate) or pulsed with arbitrary spacing; behaviour is defined per enabled edge only.

## Test plan
- Reset: hold `_reset`=0 with random `clk_en` -> `h`=0, `v`=0, `hreset`=0, `vreset`=0, `frame_odd`=0. Release and give 1 enabled edge -> `h`=1.
- Line wrap: from reset, 454 enabled edges -> `h`=454, `hreset`=1, `v`=0. 1 more edge -> `h`=0, `hreset`=0, `v`=1.
- Frame wrap: 261×455+454 = 119 209 enabled edges -> `h`=454, `v`=261, `hreset`=1, `vreset`=1. 1 more edge -> all counters 0, strobes 0, `frame_odd`=1. `vreset` measured high for exactly 455 enabled edges.
- Enable gating: `clk_en` toggled 1/0 each `mclk` -> 1 000 `mclk` edges advance `h` by exactly 500. `clk_en`=0 held 100 edges at `h`=454 -> `hreset` stays 1, `v` unchanged.
- Async reset mid-operation: assert `_reset` between `mclk` edges at `v`=130, `h`=200 -> outputs 0 before the next `mclk` edge; the next frame wrap occurs 119 210 enabled edges after release.
- Parameter override: `H_TOTAL`=4, `V_TOTAL`=3 -> `h` sequence 0,1,2,3,0 and `v` 0,1,2,0; `frame_odd` toggles every 12 enabled edges.
